// File: rtl/tpu_pkg.sv
// tpu_pkg: shared definitions for the systolic-array operand path.
//   - feeder_state_e : skew feeder FSM states
//   - FEED_DIM_DEF / FEED_STEPS_DEF : default tile size and its stream length
//   - feed_steps()   : stream length (2*DIM-1) for an arbitrary tile size
package tpu_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } feeder_state_e;

  localparam int FEED_DIM_DEF   = 8;
  // A skewed DIMxDIM tile occupies 2*DIM-1 wavefront steps.
  localparam int FEED_STEPS_DEF = 2 * FEED_DIM_DEF - 1;

  function automatic int feed_steps(input int dim);
    return 2 * dim - 1;
  endfunction

endpackage

// File: rtl/skew_lane.sv
// skew_lane: one lane of the skew feeder.
// Holds DIM operand entries for lane LANE. While the stream advances, this
// lane outputs entry (cnt - LANE) when that index is in range, else zero.
// Ports:
//   clk, rst_n : clock, async active-low reset (clears storage and output)
//   i_we       : write the whole row from i_din
//   i_din      : DIM operand elements, i_din[k] -> entry k
//   i_cnt      : shared stream step counter
//   i_clr      : force output to zero (idle / end of stream)
//   i_adv      : advance one step (load output from the indexed entry)
//   o_out      : registered operand for this lane
module skew_lane
  import tpu_pkg::*;
#(
  parameter int BITS_AB = 8,
  parameter int DIM     = FEED_DIM_DEF,
  parameter int LANE    = 0,
  parameter int CW      = $clog2(2 * DIM)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_we,
  input  logic [DIM-1:0][BITS_AB-1:0]   i_din,
  input  logic [CW-1:0]                 i_cnt,
  input  logic                          i_clr,
  input  logic                          i_adv,
  output logic [BITS_AB-1:0]            o_out
);

  localparam int IW = $clog2(DIM);

  logic [BITS_AB-1:0] r_mem [DIM];
  logic [BITS_AB-1:0] r_out;
  logic [CW:0]        w_idx;
  logic               w_vld;

  // One extra bit so cnt < LANE wraps to a large value and fails the range test.
  assign w_idx = {1'b0, i_cnt} - (CW+1)'(LANE);
  assign w_vld = (w_idx < (CW+1)'(DIM));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DIM; k++) r_mem[k] <= '0;
    end else if (i_we) begin
      for (int k = 0; k < DIM; k++) r_mem[k] <= i_din[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_out <= '0;
    else if (i_clr)  r_out <= '0;
    else if (i_adv)  r_out <= w_vld ? r_mem[w_idx[IW-1:0]] : '0;
  end

  assign o_out = r_out;

endmodule

// File: rtl/skew_feeder.sv
// skew_feeder: operand staging buffer in front of a systolic array port.
// Loads a DIMxDIM tile one lane-vector at a time while idle, then streams it
// with lane i delayed by i cycles so each array row/column sees its operands
// aligned with the wavefront.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   WrEn, Lane, Din : lane-vector write (ignored while streaming)
//   start      : begin streaming the stored tile (ignored while streaming)
//   en         : advance enable, the stream stalls while low
//   Aout       : registered skewed operand vector
//   busy       : high while streaming
//   done       : one-cycle pulse with the final vector on Aout
module skew_feeder
  import tpu_pkg::*;
#(
  parameter int BITS_AB = 8,
  parameter int DIM     = FEED_DIM_DEF
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                WrEn,
  input  logic [$clog2(DIM)-1:0]              Lane,
  input  logic signed [DIM-1:0][BITS_AB-1:0]  Din,
  input  logic                                start,
  input  logic                                en,
  output logic signed [DIM-1:0][BITS_AB-1:0]  Aout,
  output logic                                busy,
  output logic                                done
);

  localparam int CW    = $clog2(2 * DIM);
  localparam int LW    = $clog2(DIM);
  localparam int STEPS = feed_steps(DIM);

  feeder_state_e r_state;
  logic [CW-1:0] r_cnt;
  logic          r_done;

  logic          w_idle;
  logic          w_clr;
  logic          w_adv;
  logic [DIM-1:0][BITS_AB-1:0] w_out;

  assign w_idle = (r_state == IDLE);
  // The done cycle still counts as streaming; the following edge returns
  // everything to idle regardless of en, so done is a single-cycle pulse.
  assign w_clr  = w_idle || r_done;
  assign w_adv  = !w_idle && !r_done && en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt  <= '0;
          r_done <= 1'b0;
          if (start) r_state <= STREAM;
        end
        STREAM: begin
          if (r_done) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
            r_cnt   <= '0;
          end else if (en) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CW'(STEPS - 1)) r_done <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < DIM; g++) begin : g_lane
    logic w_we;
    assign w_we = w_idle && WrEn && (Lane == LW'(g));

    skew_lane #(
      .BITS_AB (BITS_AB),
      .DIM     (DIM),
      .LANE    (g),
      .CW      (CW)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .i_we  (w_we),
      .i_din (Din),
      .i_cnt (r_cnt),
      .i_clr (w_clr),
      .i_adv (w_adv),
      .o_out (w_out[g])
    );

    assign Aout[g] = w_out[g];
  end

  assign busy = !w_idle;
  assign done = r_done;

endmodule

// File: tb/tb_skew_feeder.sv
module tb_skew_feeder;

  localparam int BITS = 8;
  localparam int DIM  = 8;
  localparam int NST  = 2 * DIM - 1;

  logic                        clk;
  logic                        rst_n;
  logic                        WrEn;
  logic [2:0]                  Lane;
  logic [DIM-1:0][BITS-1:0]    Din;
  logic                        start;
  logic                        en;
  logic [DIM-1:0][BITS-1:0]    Aout;
  logic                        busy;
  logic                        done;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference copy of the tile the DUT should hold.
  logic [BITS-1:0] m [DIM][DIM];

  skew_feeder #(.BITS_AB(BITS), .DIM(DIM)) dut (
    .clk(clk), .rst_n(rst_n), .WrEn(WrEn), .Lane(Lane), .Din(Din),
    .start(start), .en(en), .Aout(Aout), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DIM-1:0][BITS-1:0] exp_vec(input int s);
    logic [DIM-1:0][BITS-1:0] r;
    for (int i = 0; i < DIM; i++) begin
      int j;
      j = s - i;
      r[i] = (j >= 0 && j < DIM) ? m[i][j] : '0;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int l, input logic [DIM-1:0][BITS-1:0] v);
    WrEn = 1'b1; Lane = 3'(l); Din = v;
    tick();
    WrEn = 1'b0;
    for (int k = 0; k < DIM; k++) m[l][k] = v[k];
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    n_tests++;
    if (Aout !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: Aout=%h busy=%b done=%b, want 0/0/0", Aout, busy, done);
    end
  endtask

  task automatic test_basic();
    logic [DIM-1:0][BITS-1:0] v;
    for (int l = 0; l < DIM; l++) begin
      for (int k = 0; k < DIM; k++) v[k] = 8'(10 * l + k);
      do_write(l, v);
    end
    do_start();
    n_tests++;
    if (busy !== 1'b1 || Aout !== '0) begin
      n_fail++;
      $display("FAIL basic_start: busy=%b Aout=%h, want 1/0", busy, Aout);
    end
    en = 1'b1;
    for (int s = 0; s < NST; s++) begin
      tick();
      n_tests++;
      if (Aout !== exp_vec(s) || done !== (s == NST - 1)) begin
        n_fail++;
        $display("FAIL basic_step%0d: Aout=%h done=%b, want %h done=%b",
                 s, Aout, done, exp_vec(s), (s == NST - 1));
      end
      if (s == 7) begin
        n_tests++;
        for (int i = 0; i < DIM; i++)
          if (Aout[i] !== 8'(10 * i + 7 - i)) begin
            n_fail++;
            $display("FAIL basic_diag lane%0d: got %0d want %0d", i, Aout[i], 10 * i + 7 - i);
          end
      end
      if (s == 14) begin
        n_tests++;
        if (Aout[7] !== 8'd77 || Aout[6:0] !== '0) begin
          n_fail++;
          $display("FAIL basic_last: Aout=%h want only lane7=77", Aout);
        end
      end
    end
    tick();
    en = 1'b0;
    n_tests++;
    if (Aout !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_after: Aout=%h busy=%b done=%b, want 0/0/0", Aout, busy, done);
    end
  endtask

  task automatic test_negative();
    logic [DIM-1:0][BITS-1:0] v;
    for (int k = 0; k < DIM; k++) v[k] = 8'(-128 + k);
    do_write(3, v);
    do_start();
    en = 1'b1;
    for (int s = 0; s < NST; s++) begin
      tick();
      if (s == 3) begin
        n_tests++;
        if ($signed(Aout[3]) !== -8'sd128) begin
          n_fail++;
          $display("FAIL neg_step3: got %0d want -128", $signed(Aout[3]));
        end
      end
      if (s == 10) begin
        n_tests++;
        if ($signed(Aout[3]) !== -8'sd121) begin
          n_fail++;
          $display("FAIL neg_step10: got %0d want -121", $signed(Aout[3]));
        end
      end
      n_tests++;
      if (Aout !== exp_vec(s)) begin
        n_fail++;
        $display("FAIL neg_step%0d: Aout=%h want %h", s, Aout, exp_vec(s));
      end
    end
    tick();
    en = 1'b0;
  endtask

  task automatic test_stall();
    int steps;
    bit seen;
    do_start();
    en = 1'b1;
    tick();
    steps = 1;
    en = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_tests++;
      if (Aout !== exp_vec(0) || done !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_hold%0d: Aout=%h done=%b busy=%b want %h 0 1",
                 c, Aout, done, busy, exp_vec(0));
      end
    end
    en = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      tick();
      steps++;
      n_tests++;
      if (Aout !== exp_vec(steps - 1)) begin
        n_fail++;
        $display("FAIL stall_step%0d: Aout=%h want %h", steps - 1, Aout, exp_vec(steps - 1));
      end
      if (done === 1'b1) seen = 1'b1;
    end
    n_tests++;
    if (!seen || steps != NST) begin
      n_fail++;
      $display("FAIL stall_count: done_seen=%b steps=%0d want 1/%0d", seen, steps, NST);
    end
    tick();
    en = 1'b0;
  endtask

  task automatic test_wr_during_stream();
    logic [DIM-1:0][BITS-1:0] nv;
    for (int k = 0; k < DIM; k++) nv[k] = 8'(200 + k);
    do_start();
    en = 1'b1;
    for (int s = 0; s < NST; s++) begin
      tick();
      if (s == 6) begin WrEn = 1'b0; start = 1'b0; end
      n_tests++;
      if (Aout !== exp_vec(s) || done !== (s == NST - 1)) begin
        n_fail++;
        $display("FAIL wrstream_step%0d: Aout=%h done=%b want %h", s, Aout, done, exp_vec(s));
      end
      if (s == 5) begin
        WrEn = 1'b1; Lane = 3'd0; Din = nv; start = 1'b1;
      end
    end
    tick();
    en = 1'b0;
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL wrstream_norestart: busy=%b want 0", busy);
    end
    // Replay: the model was never updated with nv, so old data is expected.
    do_start();
    en = 1'b1;
    for (int s = 0; s < NST; s++) begin
      tick();
      n_tests++;
      if (Aout !== exp_vec(s)) begin
        n_fail++;
        $display("FAIL wrstream_replay%0d: Aout=%h want %h", s, Aout, exp_vec(s));
      end
    end
    tick();
    en = 1'b0;
  endtask

  task automatic test_reset_mid();
    int steps;
    bit seen;
    do_start();
    en = 1'b1;
    for (int s = 0; s <= 6; s++) tick();
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (Aout !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid: Aout=%h busy=%b done=%b want 0/0/0", Aout, busy, done);
    end
    en = 1'b0;
    for (int l = 0; l < DIM; l++) for (int k = 0; k < DIM; k++) m[l][k] = '0;
    tick();
    rst_n = 1'b1;
    tick();
    do_start();
    en = 1'b1;
    steps = 0;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      tick();
      steps++;
      n_tests++;
      if (Aout !== '0) begin
        n_fail++;
        $display("FAIL rstmid_zero%0d: Aout=%h want 0", steps - 1, Aout);
      end
      if (done === 1'b1) seen = 1'b1;
    end
    n_tests++;
    if (!seen || steps != NST) begin
      n_fail++;
      $display("FAIL rstmid_count: done_seen=%b steps=%0d want 1/%0d", seen, steps, NST);
    end
    tick();
    en = 1'b0;
  endtask

  task automatic test_same_cycle();
    logic [DIM-1:0][BITS-1:0] nv;
    for (int k = 0; k < DIM; k++) nv[k] = 8'(8'h55 + k);
    WrEn = 1'b1; Lane = 3'd0; Din = nv; start = 1'b1;
    tick();
    WrEn = 1'b0; start = 1'b0;
    for (int k = 0; k < DIM; k++) m[0][k] = nv[k];
    en = 1'b1;
    tick();
    n_tests++;
    if (Aout[0] !== 8'h55 || Aout !== exp_vec(0)) begin
      n_fail++;
      $display("FAIL same_cycle_step0: Aout=%h want %h", Aout, exp_vec(0));
    end
    for (int s = 1; s < NST; s++) tick();
    tick();
    en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; WrEn = 1'b0; Lane = '0; Din = '0; start = 1'b0; en = 1'b0;
    for (int l = 0; l < DIM; l++) for (int k = 0; k < DIM; k++) m[l][k] = '0;
    #12;
    test_reset();
    rst_n = 1'b1;
    tick();
    test_basic();
    test_negative();
    test_stall();
    test_wr_during_stream();
    test_reset_mid();
    test_same_cycle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/skew_feeder.md
# skew_feeder

Operand staging buffer that sits directly upstream of the systolic array's A (or B) input port. It captures a DIM×DIM operand tile one lane-vector at a time, then streams it out with diagonal skew: lane i is delayed i cycles. Each array row (or column) therefore receives its operands aligned with the wavefront. One instance feeds A (lane = matrix row); a second instance feeds B (lane = matrix column, tile loaded transposed).

## Interface
- BITS_AB, 8, operand width (signed)
- DIM, 8, tile dimension and lane count
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- WrEn  in  1  write lane-vector Din into buffer lane Lane (IDLE only)
- Lane  in  $clog2(DIM)  destination lane for write
- Din  in  DIM×BITS_AB signed  Din[k] becomes element k of lane Lane
- start  in  1  begin streaming the stored tile (IDLE only)
- en  in  1  advance enable; stream stalls while low
- Aout  out  DIM×BITS_AB signed  skewed operand vector to the array, registered
- busy  out  1  high in STREAM
- done  out  1  one-cycle pulse, high while the final vector is on Aout

## Operation
- Storage: buf[DIM][DIM] of BITS_AB. buf[l][k] is element k of lane l.
- States: IDLE and STREAM. Step counter cnt has width $clog2(2*DIM), range 0..2*DIM-2.
- IDLE:
  - WrEn=1 writes buf[Lane][k] <= Din[k] for all k.
  - Aout <= 0, cnt <= 0, done <= 0.
  - start=1 moves to STREAM. If WrEn and start are both high in the same cycle, the write completes first and the new data is streamed.
- STREAM, with en=1:
  - For each lane i: Aout[i] <= buf[i][cnt-i] if 0 ≤ cnt-i < DIM, else 0.
  - cnt <= cnt+1.
  - When cnt == 2*DIM-2: done <= 1 and next state is IDLE.
- STREAM, with en=0: Aout, cnt, and done hold their values. done stays 0 unless it was already set.
- In STREAM, WrEn and start are ignored, so the buffer is never modified mid-stream.
- Buffer contents persist across streams. Re-issuing start replays the same tile.
- Reset (asynchronous, at any time, including mid-stream):
  - state = IDLE, cnt = 0, Aout = 0, busy = 0, done = 0.
  - All buf entries = 0.
- No arithmetic beyond the cnt-i index compare. Compute it with unsigned width $clog2(2*DIM)+1 to avoid wrap on cnt < i.

## Timing
- Edge T samples start=1. From T+1: busy=1, cnt=0.
- First en=1 edge in STREAM places step 0 on Aout: Aout[0]=buf[0][0], all other lanes 0.
- Step k is visible on Aout after the k-th en edge. A full tile takes 2*DIM-1 enabled cycles. Lane i is non-zero during steps i..i+DIM-1 only.
- Final step 2*DIM-2: Aout[DIM-1]=buf[DIM-1][DIM-1], other lanes 0, done=1 in the same cycle.
- The next edge forces Aout to 0, done to 0, and busy to 0.
- The earliest restart is start sampled on the first IDLE cycle after done.
- Write-to-stream: a write at edge T is readable by a start sampled at edge T (same-edge rule above).

## Structure
- The shared package (tpu_pkg) holds:
  - the state enum typedef {IDLE, STREAM}
  - a helper localparam for the step count, 2*DIM-1
- Sub-module skew_lane (parameters BITS_AB, DIM, LANE):
  - one DIM-entry register row with write port and index read
  - lane-local validity compare (cnt-LANE in range)
- The top level is generated over DIM instances of skew_lane, plus the FSM and counter.

## Test plan
- Load lane l with Din[k]=10*l+k (DIM=8), start, en held high. Required values:
  - step 0: Aout={0,...,0,0}, with Aout[0]=0 (buf[0][0]=0)
  - step 7: Aout[i]=10*i+(7-i)
  - step 14: only Aout[7]=77 non-zero, done=1
  - the cycle after step 14: Aout all 0 and busy=0.
- Negative operands: lane 3 loaded with −128…−121. Aout[3] carries −128 at step 3 and −121 at step 10, sign-exact.
- Stall: en toggles 1,0,0,1 during STREAM. Aout and cnt hold across the low cycles, and the total enabled steps are still 15.
- Write/start during STREAM: WrEn=1 on lane 0 with new data, plus start=1 at step 5. The remaining steps use the old data, and no restart occurs. A second start afterwards streams the data loaded before the first start.
- Reset mid-stream at step 6: Aout=0 and busy=0 asynchronously. A subsequent start with no writes streams all zeros, and done arrives 15 en-cycles later.
- Same-cycle WrEn+start in IDLE: the new lane-0 data appears at step 0.
